// File: rtl/fetch_pkg.sv
// Shared fetch-unit definitions: FSM states, parameter defaults, slot-width helper.
package fetch_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h8000_0000;
  localparam int unsigned DEF_FETCH_WIDTH  = 2;
  localparam int unsigned DEF_QUEUE_DEPTH  = 4;
  localparam int unsigned DEF_BOOT_DELAY   = 1;

  // Width of a slot index within a fetch group (never below one bit).
  function automatic int unsigned slot_w(input int unsigned fw);
    return (fw > 1) ? $clog2(fw) : 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Fetch-group FIFO with synchronous flush; head reads as zero when empty.
module fetch_queue #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty qualification uses the occupancy at the start of the cycle.
  always_comb begin
    push_ok = push_i && (count_q != CW'(DEPTH));
    pop_ok  = pop_i && (count_q != '0);
  end

  // Pointer and occupancy tracking; flush drops every stored group.
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Group storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_addr_gen.sv
// Fetch address generator: boots at RESET_VECTOR, builds fetch groups from
// sequential/predicted flow, queues them, and redirects on writeback flush.
module fetch_addr_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int unsigned FETCH_WIDTH  = DEF_FETCH_WIDTH,
  parameter int unsigned QUEUE_DEPTH  = DEF_QUEUE_DEPTH,
  parameter int unsigned BOOT_DELAY   = DEF_BOOT_DELAY
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush_i,
  input  logic [31:0]                      wtarget_i,
  output logic [31:0]                      pred_pc_o,
  input  logic                             pvalid_i,
  input  logic                             ptaken_i,
  input  logic [slot_w(FETCH_WIDTH)-1:0]   pslot_i,
  input  logic [31:0]                      ptarget_i,
  output logic                             valid_post_o,
  input  logic                             ready_post_i,
  output logic [31:0]                      pc_o,
  output logic [FETCH_WIDTH-1:0]           mask_o,
  output logic [$clog2(QUEUE_DEPTH):0]     count_o
);

  localparam int unsigned SW          = slot_w(FETCH_WIDTH);
  localparam int unsigned CW          = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned BW          = $clog2(BOOT_DELAY + 1);
  localparam int unsigned ENT_W       = 32 + FETCH_WIDTH;
  // Byte offset within a group; a one-wide group only drops the word offset.
  localparam int unsigned OFF_W       = 2 + $clog2(FETCH_WIDTH);
  localparam logic [31:0] OFF_MASK    = 32'((64'd1 << OFF_W) - 64'd1);
  localparam logic [31:0] GROUP_BYTES = 32'(4 * FETCH_WIDTH);

  fetch_state_e            state_q;
  logic [BW-1:0]           boot_cnt_q;
  logic [31:0]             gen_pc_q;

  logic [SW-1:0]           start_slot;
  logic                    taken;
  logic [FETCH_WIDTH-1:0]  grp_mask;
  logic [31:0]             next_pc;
  logic                    run;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    flush_run;
  logic [ENT_W-1:0]        head;
  logic [CW-1:0]           count;

  // Group mask and successor address from the current fetch PC and prediction.
  always_comb begin
    start_slot = '0;
    if (FETCH_WIDTH > 1) start_slot = gen_pc_q[2 +: SW];
    taken = pvalid_i && ptaken_i && (pslot_i >= start_slot);
    grp_mask = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      grp_mask[i] = (SW'(i) >= start_slot) && (!taken || (SW'(i) <= pslot_i));
    end
    next_pc = taken ? (ptarget_i & ~32'h3) : ((gen_pc_q & ~OFF_MASK) + GROUP_BYTES);
  end

  // Queue control: flush wins over enqueue/dequeue; full uses pre-dequeue count.
  always_comb begin
    run       = (state_q == ST_RUN);
    full      = (count == CW'(QUEUE_DEPTH));
    flush_run = run && flush_i;
    push      = run && !flush_i && !full;
    pop       = valid_post_o && ready_post_i;
  end

  // Boot sequencing and fetch-PC register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      gen_pc_q   <= '0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          if (boot_cnt_q == BW'(BOOT_DELAY - 1)) begin
            state_q  <= ST_RUN;
            gen_pc_q <= RESET_VECTOR;
          end else begin
            boot_cnt_q <= boot_cnt_q + BW'(1);
          end
        end
        ST_RUN: begin
          if (flush_i)   gen_pc_q <= wtarget_i & ~32'h3;
          else if (push) gen_pc_q <= next_pc;
        end
      endcase
    end
  end

  fetch_queue #(
    .WIDTH (ENT_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock   (clock),
    .reset   (reset),
    .flush_i (flush_run),
    .push_i  (push),
    .data_i  ({gen_pc_q, grp_mask}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count)
  );

  assign pred_pc_o    = gen_pc_q;
  assign valid_post_o = (count != '0);
  assign pc_o         = head[ENT_W-1 -: 32];
  assign mask_o       = head[FETCH_WIDTH-1:0];
  assign count_o      = count;

endmodule
